shift_pattern_controller: RTL and testbench

//  Command-driven sequencer for a W-bit LED shift register.

---
 rtl/shift_ctrl_pkg.sv | 17 +
 rtl/step_prescaler.sv | 19 +
 rtl/shift_pattern_controller.sv | 80 ++++++++
 tb/tb_shift_pattern_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: opcodes, FSM states and the single-step shift/rotate function.
package shift_ctrl_pkg;
    localparam int PW = 32;
    localparam int PI = $clog2(PW);
    typedef enum logic [2:0] {OP_LOAD, OP_SHR, OP_SHL, OP_ROR, OP_ROL, OP_CLEAR, OP_RSV6, OP_RSV7} op_e;
    typedef enum logic {IDLE, RUN} state_e;
    function automatic logic [PW-1:0] next_pattern(input op_e op, input logic [PW-1:0] p,
                                                   input logic sin, input logic [PI-1:0] msb);
        logic [PW-1:0] r;
        r = (op == OP_SHR || op == OP_ROR) ? p >> 1 : (op == OP_SHL || op == OP_ROL) ? p << 1 : p;
        if (op == OP_SHR) r[msb] = sin;
        if (op == OP_ROR) r[msb] = p[0];
        if (op == OP_SHL) r[0] = sin;
        if (op == OP_ROL) r[0] = p[msb];
        return r;
    endfunction
endpackage

// File: rtl/step_prescaler.sv
// step_prescaler: emits one tick every DIV enabled cycles; clear restarts the count.
module step_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = en && (cnt_q == CW'(DIV - 1));
    always_comb cnt_d = (clear || tick) ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/shift_pattern_controller.sv
// shift_pattern_controller: command-driven load/clear/shift/rotate sequencer for a W-bit pattern.
module shift_pattern_controller
    import shift_ctrl_pkg::*;
#(
    parameter int W   = 4,
    parameter int DIV = 2**23,
    parameter int SW  = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [SW-1:0] cmd_steps,
    input  logic [W-1:0]  cmd_data,
    input  logic          serial_in,
    input  logic          abort,
    output logic [W-1:0]  pattern,
    output logic          busy,
    output logic          done
);
    state_e        state_q, state_d;
    op_e           op_q, op_d;
    logic [W-1:0]  pattern_q, pattern_d, stepped;
    logic [SW-1:0] remaining_q, remaining_d;
    logic          done_q, done_d, tick, start;
    op_e           cop;
    assign cop       = op_e'(cmd_op);
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign pattern   = pattern_q;
    assign done      = done_q;
    assign start     = cmd_valid && cmd_ready && (cop inside {OP_SHR, OP_SHL, OP_ROR, OP_ROL});
    assign stepped   = W'(next_pattern(op_q, PW'(pattern_q), serial_in, PI'(W - 1)));
    step_prescaler #(.DIV(DIV)) u_presc (
        .clk(clk), .reset_n(reset_n), .clear(start), .en(busy), .tick(tick)
    );
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pattern_d   = pattern_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                state_d     = RUN;
                op_d        = cop;
                remaining_d = cmd_steps;
            end else if (cmd_valid) begin
                done_d    = 1'b1;
                pattern_d = (cop == OP_LOAD) ? cmd_data : (cop == OP_CLEAR) ? '0 : pattern_q;
            end
        end else if (abort) begin
            state_d = IDLE;
        end else if (tick) begin
            pattern_d = stepped;
            if (remaining_q == SW'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else if (remaining_q != '0) begin
                remaining_d = remaining_q - 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= OP_LOAD;
            pattern_q   <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            pattern_q   <= pattern_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end
endmodule

// File: tb/tb_shift_pattern_controller.sv
// tb_shift_pattern_controller: directed stimulus with a cycle-stamped expectation scoreboard.
module tb_shift_pattern_controller;
    logic       clk = 1'b0;
    logic       reset_n, cmd_valid4, cmd_valid1, serial_in, abort;
    logic [2:0] cmd_op;
    logic [7:0] cmd_steps;
    logic [3:0] cmd_data;
    logic       rdy4, rdy1, busy4, busy1, done4, done1;
    logic [3:0] pat4, pat1;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    typedef struct {
        int         at;
        bit         s;
        logic [3:0] p;
        bit         b;
        bit         d;
        bit         r;
        string      n;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_pattern_controller #(.W(4), .DIV(4), .SW(8)) u4 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid4), .cmd_ready(rdy4),
        .cmd_op(cmd_op), .cmd_steps(cmd_steps), .cmd_data(cmd_data), .serial_in(serial_in),
        .abort(abort), .pattern(pat4), .busy(busy4), .done(done4)
    );
    shift_pattern_controller #(.W(4), .DIV(1), .SW(8)) u1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(rdy1),
        .cmd_op(cmd_op), .cmd_steps(cmd_steps), .cmd_data(cmd_data), .serial_in(serial_in),
        .abort(abort), .pattern(pat1), .busy(busy1), .done(done1)
    );

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                logic [6:0] got, want;
                got  = sb[i].s ? {pat1, busy1, done1, rdy1} : {pat4, busy4, done4, rdy4};
                want = {sb[i].p, sb[i].b, sb[i].d, sb[i].r};
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got pat=%b busy=%b done=%b ready=%b want pat=%b busy=%b done=%b ready=%b",
                             sb[i].n, cyc, got[6:3], got[2], got[1], got[0],
                             want[6:3], want[2], want[1], want[0]);
                end
                sb.delete(i);
            end
        end
    end

    task automatic ex(input int at, input bit s, input logic [3:0] p, input bit b,
                      input bit d, input bit r, input string n);
        exp_t e;
        e.at = at; e.s = s; e.p = p; e.b = b; e.d = d; e.r = r; e.n = n;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d pending=%0d", cyc, sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset_n = 1'b0; cmd_valid4 = 1'b1; cmd_valid1 = 1'b1; abort = 1'b0; serial_in = 1'b0;
        cmd_op = 3'd0; cmd_data = 4'hF; cmd_steps = 8'd0;
        for (int k = 1; k <= 3; k++) begin
            ex(k, 0, 4'b0000, 0, 0, 1, "reset_u4");
            ex(k, 1, 4'b0000, 0, 0, 1, "reset_u1");
        end
        ex(4, 0, 4'b0000, 0, 0, 1, "post_reset_u4");
        ex(4, 1, 4'b0000, 0, 0, 1, "post_reset_u1");
        wait_to(3);
        reset_n = 1'b1; cmd_valid4 = 1'b0; cmd_valid1 = 1'b0;

        // ROR x3 from 1001, DIV=4
        wait_to(5); c = cyc;
        cmd_op = 3'd0; cmd_data = 4'b1001; cmd_valid4 = 1'b1;
        ex(c + 1, 0, 4'b1001, 0, 1, 1, "t2_load");
        @(negedge clk); cmd_op = 3'd3; cmd_steps = 8'd3;
        ex(c + 2, 0, 4'b1001, 1, 0, 0, "t2_run");
        ex(c + 5, 0, 4'b1001, 1, 0, 0, "t2_pre_step1");
        ex(c + 6, 0, 4'b1100, 1, 0, 0, "t2_step1");
        ex(c + 10, 0, 4'b0110, 1, 0, 0, "t2_step2");
        ex(c + 13, 0, 4'b0110, 1, 0, 0, "t2_pre_step3");
        ex(c + 14, 0, 4'b0011, 0, 1, 1, "t2_step3_done");
        ex(c + 15, 0, 4'b0011, 0, 0, 1, "t2_done_one_cycle");
        @(negedge clk); cmd_valid4 = 1'b0;
        wait_to(c + 16);

        // continuous SHR with serial_in=1, aborted after 6 ticks
        c = cyc;
        cmd_op = 3'd5; cmd_valid4 = 1'b1;
        ex(c + 1, 0, 4'b0000, 0, 1, 1, "t3_clear");
        @(negedge clk); cmd_op = 3'd1; cmd_steps = 8'd0; serial_in = 1'b1;
        ex(c + 2, 0, 4'b0000, 1, 0, 0, "t3_run");
        ex(c + 6, 0, 4'b1000, 1, 0, 0, "t3_tick1");
        ex(c + 10, 0, 4'b1100, 1, 0, 0, "t3_tick2");
        ex(c + 14, 0, 4'b1110, 1, 0, 0, "t3_tick3");
        ex(c + 18, 0, 4'b1111, 1, 0, 0, "t3_tick4");
        ex(c + 22, 0, 4'b1111, 1, 0, 0, "t3_tick5");
        ex(c + 26, 0, 4'b1111, 1, 0, 0, "t3_tick6");
        @(negedge clk); cmd_valid4 = 1'b0;
        wait_to(c + 26); abort = 1'b1;
        ex(c + 27, 0, 4'b1111, 0, 0, 1, "t3_abort");
        ex(c + 28, 0, 4'b1111, 0, 0, 1, "t3_abort_hold");
        @(negedge clk); abort = 1'b0; serial_in = 1'b0;
        wait_to(c + 29);

        // abort coincident with the second tick of a ROL
        c = cyc;
        cmd_op = 3'd0; cmd_data = 4'b0101; cmd_valid4 = 1'b1;
        ex(c + 1, 0, 4'b0101, 0, 1, 1, "t4_load");
        @(negedge clk); cmd_op = 3'd4; cmd_steps = 8'd5;
        ex(c + 2, 0, 4'b0101, 1, 0, 0, "t4_run");
        ex(c + 6, 0, 4'b1010, 1, 0, 0, "t4_tick1");
        ex(c + 9, 0, 4'b1010, 1, 0, 0, "t4_pre_abort");
        @(negedge clk); cmd_valid4 = 1'b0;
        wait_to(c + 9); abort = 1'b1;
        ex(c + 10, 0, 4'b1010, 0, 0, 1, "t4_abort_beats_tick");
        ex(c + 11, 0, 4'b1010, 0, 0, 1, "t4_idle_hold");
        @(negedge clk); abort = 1'b0;
        wait_to(c + 12);

        // reset mid-run, then a normal LOAD
        c = cyc;
        cmd_op = 3'd0; cmd_data = 4'b0001; cmd_valid4 = 1'b1;
        ex(c + 1, 0, 4'b0001, 0, 1, 1, "t6_load");
        @(negedge clk); cmd_op = 3'd2; cmd_steps = 8'd10; serial_in = 1'b0;
        ex(c + 2, 0, 4'b0001, 1, 0, 0, "t6_run");
        ex(c + 6, 0, 4'b0010, 1, 0, 0, "t6_tick1");
        ex(c + 10, 0, 4'b0100, 1, 0, 0, "t6_tick2");
        ex(c + 14, 0, 4'b1000, 1, 0, 0, "t6_tick3");
        @(negedge clk); cmd_valid4 = 1'b0;
        wait_to(c + 14); reset_n = 1'b0;
        ex(c + 15, 0, 4'b0000, 0, 0, 1, "t6_reset");
        ex(c + 16, 0, 4'b0000, 0, 0, 1, "t6_no_done");
        @(negedge clk); reset_n = 1'b1;
        wait_to(c + 16);
        cmd_op = 3'd0; cmd_data = 4'b0110; cmd_valid4 = 1'b1;
        ex(c + 17, 0, 4'b0110, 0, 1, 1, "t6_load_after");
        ex(c + 18, 0, 4'b0110, 0, 0, 1, "t6_load_done_clr");
        @(negedge clk); cmd_valid4 = 1'b0;
        wait_to(c + 19);

        // DIV=1 ROL x4 with a held second command
        c = cyc;
        cmd_op = 3'd0; cmd_data = 4'b0010; cmd_valid1 = 1'b1;
        ex(c + 1, 1, 4'b0010, 0, 1, 1, "t5_load");
        @(negedge clk); cmd_op = 3'd4; cmd_steps = 8'd4;
        ex(c + 2, 1, 4'b0010, 1, 0, 0, "t5_run");
        ex(c + 3, 1, 4'b0100, 1, 0, 0, "t5_step1");
        ex(c + 4, 1, 4'b1000, 1, 0, 0, "t5_step2");
        ex(c + 5, 1, 4'b0001, 1, 0, 0, "t5_step3");
        ex(c + 6, 1, 4'b0010, 0, 1, 1, "t5_step4_done");
        ex(c + 7, 1, 4'b1111, 0, 1, 1, "t5_held_accept");
        ex(c + 8, 1, 4'b1111, 0, 0, 1, "t5_final");
        @(negedge clk); cmd_op = 3'd0; cmd_data = 4'b1111;
        wait_to(c + 7); cmd_valid1 = 1'b0;
        wait_to(c + 10);

        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain pending=%0d want 0", sb.size());
            failures += sb.size();
            checks += sb.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
